// File: rtl/das_pkg.sv
// Shared FSM encoding and helpers for the multi-channel acquisition buffer.
// Circular capture is a build-time option selected with DAS_CIRCULAR_EN (off by default).
package das_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SNAP,
        ST_WRITE,
        ST_DONE
    } das_state_e;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/das_tick_gen.sv
// Sample-tick divider: free-running 0..DIV-1 counter with synchronous clear.
// tick_o is high during the last count of each period.
module das_tick_gen
    import das_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_q <= '0;
        end else if (clr_i || (div_q == LAST)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick_o = (div_q == LAST);

endmodule

// File: rtl/das_multi_channel.sv
// Multi-channel acquisition buffer: snapshots NCH channels per tick into a DEPTH-word RAM.
// Build option DAS_CIRCULAR_EN turns the one-shot capture into a wrap-around capture ended by stop_i.
//
//   state    | meaning
//   ST_IDLE  | no capture since reset
//   ST_ARM   | waiting for the next sample tick
//   ST_SNAP  | registering all channels
//   ST_WRITE | storing one enabled channel per cycle, lowest index first
//   ST_DONE  | capture finished, buffer readable
module das_multi_channel
    import das_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NCH   = 4,
    parameter int DEPTH = 16,
    parameter int DIV   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NCH*DW-1:0]          data_in_i,
    input  logic [NCH-1:0]             ch_mask_i,
    input  logic                       load_i,
    input  logic                       stop_i,
    input  logic                       read_i,
    input  logic [$clog2(DEPTH)-1:0]   address_i,
    output logic [DW-1:0]              data_out_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    if (DIV < NCH + 1) begin : g_div_chk
        $error("das_multi_channel: DIV must be at least NCH+1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("das_multi_channel: DEPTH must be a power of two, at least 2");
    end
    if (NCH > 32) begin : g_nch_chk
        $error("das_multi_channel: NCH must not exceed 32");
    end

    das_state_e        state_q;
    logic [NCH-1:0]    mask_q;
    logic [NCH-1:0]    rem_q;
    logic [NCH-1:0]    rem_d;
    logic [NCH*DW-1:0] snap_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW:0]       count_q;
    logic              busy_q;
    logic              done_q;
    logic [DW-1:0]     data_out_q;
    logic [DW-1:0]     mem [DEPTH];

    logic              tick;
    logic              load_ok;
    logic              last_ch;
    logic              stop_now;
    logic              end_capture;
    logic [4:0]        cur_idx;
    logic [DW-1:0]     wr_data;
    logic [AW-1:0]     rd_phys;

    assign load_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && load_i && (ch_mask_i != '0);
    assign cur_idx = lowest_set(32'(rem_q));
    assign wr_data = snap_q[int'(cur_idx)*DW +: DW];
    assign rem_d   = rem_q & (rem_q - 1'b1);
    assign last_ch = (rem_d == '0);

    das_tick_gen #(.DIV(DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (load_ok),
        .tick_o (tick)
    );

`ifdef DAS_CIRCULAR_EN
    logic stop_pend_q;

    // A stop seen mid-snapshot is held until that snapshot is fully stored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stop_pend_q <= 1'b0;
        end else if (load_ok) begin
            stop_pend_q <= 1'b0;
        end else if (stop_i && ((state_q == ST_SNAP) || (state_q == ST_WRITE))) begin
            stop_pend_q <= 1'b1;
        end
    end

    assign stop_now    = stop_i;
    assign end_capture = last_ch && (stop_pend_q || stop_i);
    assign rd_phys     = (count_q == FULL) ? (wr_ptr_q + address_i) : address_i;
`else
    logic unused_stop;

    assign unused_stop = stop_i;
    assign stop_now    = 1'b0;
    assign end_capture = (count_q == (FULL - 1'b1));
    assign rd_phys     = address_i;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            rem_q    <= '0;
            snap_q   <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (load_ok) begin
                        state_q  <= ST_ARM;
                        mask_q   <= ch_mask_i;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (stop_now) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick) begin
                        state_q <= ST_SNAP;
                    end
                end
                ST_SNAP: begin
                    snap_q  <= data_in_i;
                    rem_q   <= mask_q;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    rem_q    <= rem_d;
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (count_q != FULL) count_q <= count_q + 1'b1;
                    if (end_capture) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (last_ch) begin
                        // With DIV == NCH+1 the next tick lands on the final write.
                        state_q <= tick ? ST_SNAP : ST_ARM;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_WRITE) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_out_q <= '0;
        end else if (read_i) begin
            data_out_q <= ({1'b0, address_i} < count_q) ? mem[rd_phys] : '0;
        end
    end

    assign data_out_o = data_out_q;
    assign count_o    = count_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_das_multi_channel.sv
// Bench for das_multi_channel: random channel data, a queue-based reference of buffer contents,
// and a read scoreboard drained by an independent monitor.
module tb_das_multi_channel;

    localparam int DW    = 8;
    localparam int NCH   = 4;
    localparam int DEPTH = 16;
    localparam int DIV   = 8;
    localparam int AW    = 4;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NCH*DW-1:0] data_in  = '0;
    logic [NCH-1:0]    ch_mask  = '0;
    logic              load     = 1'b0;
    logic              stop     = 1'b0;
    logic              read     = 1'b0;
    logic [AW-1:0]     address  = '0;
    logic [DW-1:0]     data_out;
    logic [AW:0]       count;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int            addr;
        logic [DW-1:0] val;
    } rd_exp_t;

    rd_exp_t           exp_q[$];
    logic [NCH*DW-1:0] samples [64];
    logic [DW-1:0]     model[$];
    logic              rd_seen = 1'b0;

    always #5 clk = ~clk;

    das_multi_channel #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .data_in_i (data_in),
        .ch_mask_i (ch_mask),
        .load_i    (load),
        .stop_i    (stop),
        .read_i    (read),
        .address_i (address),
        .data_out_o(data_out),
        .count_o   (count),
        .busy_o    (busy),
        .done_o    (done)
    );

    // Read data appears after the edge that samples the strobe.
    always @(posedge clk) rd_seen <= read;

    always @(negedge clk) begin
        if (rd_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: data_out=%h with no read outstanding", data_out);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (data_out !== e.val) begin
                    n_err++;
                    $display("FAIL rd_addr%0d: got %h expected %h", e.addr, data_out, e.val);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic rand_samples(input int n);
        for (int s = 0; s < n; s++)
            for (int c = 0; c < NCH; c++)
                samples[s][c*DW +: DW] = DW'($urandom);
    endtask

    // Reference: enabled channels of each snapshot in ascending order; one-shot stops at DEPTH,
    // circular keeps the newest DEPTH words, oldest first.
    task automatic build_model(input logic [NCH-1:0] m, input int nsnap, input bit circ);
        model.delete();
        for (int s = 0; s < nsnap; s++)
            for (int c = 0; c < NCH; c++)
                if (m[c]) begin
                    if (circ) begin
                        model.push_back(samples[s][c*DW +: DW]);
                        if (model.size() > DEPTH) void'(model.pop_front());
                    end else if (model.size() < DEPTH) begin
                        model.push_back(samples[s][c*DW +: DW]);
                    end
                end
    endtask

    function automatic logic [DW-1:0] exp_val(input int a);
        if (a < model.size()) return model[a];
        return '0;
    endfunction

    // All tasks below start and end 1ns after a rising edge.
    task automatic do_load(input logic [NCH-1:0] m);
        ch_mask = m;
        load    = 1'b1;
        @(posedge clk); #1;
        load    = 1'b0;
    endtask

    // Data for sample n is held from 4 cycles after the load edge + n*DIV for a full period,
    // so the snapshot taken after tick n+1 sees it regardless of where in the window it samples.
    task automatic drive_samples(input int n);
        for (int s = 0; s < n; s++) begin
            if (s == 0) repeat (4) @(posedge clk);
            else        repeat (DIV) @(posedge clk);
            #1;
            data_in = samples[s];
        end
    endtask

    task automatic do_read(input int a, input logic [DW-1:0] v);
        rd_exp_t e;
        e.addr  = a;
        e.val   = v;
        read    = 1'b1;
        address = AW'(a);
        exp_q.push_back(e);
        @(posedge clk); #1;
        read    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
        end
        check(name, done, 1);
    endtask

    task automatic wait_count(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (count == (AW + 1)'(target)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) do_read(a, exp_val(a));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        // Reset defaults
        #12;
        check("rst_data_out", data_out, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // load with an empty mask is ignored
        do_load('0);
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("mask0_busy", busy, 0);
        check("mask0_done", done, 0);
        check("mask0_count", count, 0);

`ifdef DAS_CIRCULAR_EN
        // Circular: 20 ticks on ch0 then stop; buffer keeps samples 4..19
        rand_samples(20);
        build_model(4'b0001, 20, 1'b1);
        do_load(4'b0001);
        drive_samples(20);
        repeat (DIV) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        wait_done("circ_done", 40);
        check("circ_count", count, DEPTH);
        check("circ_busy", busy, 0);
        do_read(0, samples[4][DW-1:0]);
        do_read(15, samples[19][DW-1:0]);
        for (int i = 0; i < 8; i++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            do_read(a, exp_val(a));
        end
`else
        // Basic capture, mask 0101: ch0 = A0+n, ch2 = C0+n
        rand_samples(8);
        for (int s = 0; s < 8; s++) begin
            samples[s][0*DW +: DW] = 8'hA0 + 8'(s);
            samples[s][2*DW +: DW] = 8'hC0 + 8'(s);
        end
        build_model(4'b0101, 8, 1'b0);
        do_load(4'b0101);
        check("basic_busy_start", busy, 1);
        check("basic_done_start", done, 0);
        drive_samples(8);
        wait_done("basic_done", 100);
        check("basic_count", count, DEPTH);
        check("basic_busy_end", busy, 0);
        do_read(3, 8'hC1);
        for (int i = 0; i < 16; i++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            do_read(a, exp_val(a));
        end

        // Partial final snapshot, mask 0111; a stop pulse must be ignored
        rand_samples(6);
        build_model(4'b0111, 6, 1'b0);
        do_load(4'b0111);
        fork
            drive_samples(6);
            begin
                repeat (20) @(posedge clk);
                #1;
                stop = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;
                check("partial_stop_ignored", busy, 1);
            end
        join
        wait_done("partial_done", 100);
        check("partial_count", count, DEPTH);
        read_all();

        // Load while busy is ignored; out-of-range read returns 0
        rand_samples(4);
        build_model(4'b1111, 4, 1'b0);
        do_load(4'b1111);
        fork
            drive_samples(4);
            begin
                wait_count(4, 4 * DIV, ok);
                check("busy_count4_reached", ok, 1);
                do_read(10, '0);
                do_read(1, exp_val(1));
                ch_mask = 4'b0001;
                load    = 1'b1;
                @(posedge clk); #1;
                load    = 1'b0;
                check("busy_load_no_restart", busy, 1);
            end
        join
        wait_done("busy_done", 100);
        check("busy_count", count, DEPTH);
        read_all();

        // Reset during the second snapshot, then a fresh capture from address 0
        rand_samples(2);
        do_load(4'b1111);
        fork
            drive_samples(2);
            begin
                wait_count(5, 4 * DIV, ok);
                check("rstmid_count5_reached", ok, 1);
                rst_n = 1'b0;
                #1;
                check("rstmid_count", count, 0);
                check("rstmid_busy", busy, 0);
                check("rstmid_done", done, 0);
                check("rstmid_data_out", data_out, 0);
            end
        join
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid_idle_busy", busy, 0);
        do_read(0, '0);
        rand_samples(8);
        build_model(4'b0011, 8, 1'b0);
        do_load(4'b0011);
        drive_samples(8);
        wait_done("rstmid_redo_done", 100);
        check("rstmid_redo_count", count, DEPTH);
        read_all();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
